sw_debounce_sync: RTL and testbench

- Conditions raw board switch inputs before they reach the switch PIO's `in_port`.
- Pipeline per bit: 2-flop metastability synchronizer, shared sample-tick divider, per-bit N-sample stability filter.
- Outputs: debounced level vector (drives the PIO `in_port`), plus single-cycle rise/fall/changed pulses for future edge-capture/IRQ logic.

---
 rtl/sw_debounce_sync.sv | 92 +++++++++
 tb/tb_sw_debounce_sync.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/sw_debounce_sync.sv
// Switch conditioner: 2-flop synchronizer, shared sample-tick divider and
// per-bit N-sample stability filter with registered level and edge pulses.
module sw_debounce_sync #(
  parameter int WIDTH          = 32,
  parameter int TICK_DIV       = 50000,
  parameter int STABLE_SAMPLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_debounced,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             sw_changed,
  output logic             sample_tick
);

  localparam int               CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;
  logic [CNT_W-1:0] r_cnt;
  logic             r_tick;
  logic [WIDTH-1:0] r_deb;
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;
  logic             r_changed;
  logic [WIDTH-1:0] w_rise_next;
  logic [WIDTH-1:0] w_fall_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= sw_raw;
      r_s2 <= r_s1;
    end
  end

  // With TICK_DIV=1 the counter is pinned at 0 and the tick fires every cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_cnt  <= (r_cnt == CNT_LAST) ? '0 : r_cnt + CNT_ONE;
      r_tick <= (r_cnt == CNT_LAST);
    end
  end

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : gen_bit
      logic [STABLE_SAMPLES-1:0] r_hist;

      always_ff @(posedge clk) begin
        if (reset) begin
          r_hist <= '0;
        end else if (r_tick) begin
          r_hist <= {r_hist[STABLE_SAMPLES-2:0], r_s2[gi]};
        end
      end

      // Only a unanimous history can flip the level; mixed history holds it.
      assign w_rise_next[gi] = (&r_hist) & ~r_deb[gi];
      assign w_fall_next[gi] = ~(|r_hist) & r_deb[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_deb     <= '0;
      r_rise    <= '0;
      r_fall    <= '0;
      r_changed <= 1'b0;
    end else begin
      r_deb     <= (r_deb | w_rise_next) & ~w_fall_next;
      r_rise    <= w_rise_next;
      r_fall    <= w_fall_next;
      r_changed <= |(w_rise_next | w_fall_next);
    end
  end

  assign sw_debounced = r_deb;
  assign sw_rise      = r_rise;
  assign sw_fall      = r_fall;
  assign sw_changed   = r_changed;
  assign sample_tick  = r_tick;

endmodule

// File: tb/tb_sw_debounce_sync.sv
// Directed bench: one 4-bit instance with TICK_DIV=4/N=3 and one with
// TICK_DIV=1/N=2, checked against hand-derived levels, pulses and latencies.
module tb_sw_debounce_sync;

  logic       clk = 1'b0;
  logic       reset_a, reset_b;
  logic [3:0] raw_a, raw_b;
  logic [3:0] deb_a, rise_a, fall_a, deb_b, rise_b, fall_b;
  logic       chg_a, tick_a, chg_b, tick_b;

  int n_vec = 0;
  int n_err = 0;
  int lat, first1, n_ticks, first_tick, last_tick, bad_gap, pulses;
  int rise_cnt, chg_cnt, rise_val, guard, hi_cnt, low_tick;

  always #5 clk = ~clk;

  sw_debounce_sync #(.WIDTH(4), .TICK_DIV(4), .STABLE_SAMPLES(3)) dut_a (
    .clk(clk), .reset(reset_a), .sw_raw(raw_a),
    .sw_debounced(deb_a), .sw_rise(rise_a), .sw_fall(fall_a),
    .sw_changed(chg_a), .sample_tick(tick_a)
  );

  sw_debounce_sync #(.WIDTH(4), .TICK_DIV(1), .STABLE_SAMPLES(2)) dut_b (
    .clk(clk), .reset(reset_b), .sw_raw(raw_b),
    .sw_debounced(deb_b), .sw_rise(rise_b), .sw_fall(fall_b),
    .sw_changed(chg_b), .sample_tick(tick_b)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: got=%0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_deb_a(input logic [3:0] tgt, output int l);
    l = -1;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (deb_a == tgt) begin
        l = k;
        break;
      end
    end
  endtask

  initial begin
    // ---- reset state and idle tick period ----
    reset_a = 1'b1; reset_b = 1'b1; raw_a = 4'b0000; raw_b = 4'b0000;
    step(); step();
    chk("rst_deb",   int'(deb_a),  0);
    chk("rst_rise",  int'(rise_a), 0);
    chk("rst_fall",  int'(fall_a), 0);
    chk("rst_chg",   int'(chg_a),  0);
    chk("rst_tick",  int'(tick_a), 0);
    chk("rst_deb_b", int'(deb_b),  0);
    reset_a = 1'b0; reset_b = 1'b0;
    n_ticks = 0; first_tick = -1; last_tick = -1; bad_gap = 0; pulses = 0;
    for (int k = 1; k <= 50; k++) begin
      step();
      if (tick_a) begin
        if (first_tick < 0) first_tick = k;
        else if (k - last_tick != 4) bad_gap++;
        last_tick = k;
        n_ticks++;
      end
      if (rise_a != 0 || fall_a != 0 || chg_a || deb_a != 0) pulses++;
    end
    chk("idle_first_tick", first_tick, 4);
    chk("idle_tick_count", n_ticks, 12);
    chk("idle_tick_gap",   bad_gap, 0);
    chk("idle_quiet",      pulses, 0);

    // ---- step 0 -> 0101 ----
    raw_a = 4'b0101; lat = -1; rise_cnt = 0; chg_cnt = 0; rise_val = 0;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (lat < 0 && deb_a != 0) lat = k;
      if (rise_a != 0) begin rise_cnt++; rise_val = int'(rise_a); end
      if (chg_a) chg_cnt++;
    end
    chk("step_lat_in_11_15", int'(lat >= 11 && lat <= 15), 1);
    chk("step_deb",       int'(deb_a), 'b0101);
    chk("step_rise_val",  rise_val, 'b0101);
    chk("step_rise_cycles", rise_cnt, 1);
    chk("step_chg_cycles",  chg_cnt, 1);

    // ---- bounce on bit0, aligned to the tick phase ----
    raw_a = 4'b0100;
    wait_deb_a(4'b0100, lat);
    chk("clr_bit0", int'(deb_a), 'b0100);
    guard = 0;
    while (!tick_a && guard < 10) begin step(); guard++; end
    chk("tick_found", int'(tick_a), 1);
    step();
    first1 = -1;
    for (int k = 0; k < 38; k++) begin
      if (k < 18) raw_a[0] = (((k / 3) % 2) == 0);
      else        raw_a[0] = 1'b1;
      step();
      if (first1 < 0 && deb_a[0]) first1 = k;
    end
    chk("bounce_rise_at", first1, 32);
    chk("bounce_deb",     int'(deb_a), 'b0101);

    // ---- simultaneous fall of bits 3 and 0 ----
    raw_a = 4'b1111;
    wait_deb_a(4'b1111, lat);
    chk("all_ones", int'(deb_a), 'b1111);
    raw_a = 4'b0110;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (deb_a != 4'b1111) begin lat = k; break; end
    end
    chk("fall_seen",  int'(lat > 0), 1);
    chk("fall_deb",   int'(deb_a),  'b0110);
    chk("fall_vec",   int'(fall_a), 'b1001);
    chk("fall_rise0", int'(rise_a), 0);
    chk("fall_chg",   int'(chg_a),  1);
    step();
    chk("fall_vec_end", int'(fall_a), 0);
    chk("fall_chg_end", int'(chg_a),  0);

    // ---- reset after two qualifying ticks ----
    raw_a = 4'b1111; reset_a = 1'b1;
    step();
    chk("mid_rst_deb", int'(deb_a), 0);
    reset_a = 1'b0;
    n_ticks = 0; guard = 0;
    while (n_ticks < 2 && guard < 20) begin
      step(); guard++;
      if (tick_a) n_ticks++;
    end
    step();
    chk("pre_rst_deb", int'(deb_a), 0);
    reset_a = 1'b1;
    step();
    chk("rst2_deb",  int'(deb_a),  0);
    chk("rst2_tick", int'(tick_a), 0);
    chk("rst2_rise", int'(rise_a), 0);
    reset_a = 1'b0;
    lat = -1; n_ticks = 0;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (tick_a) n_ticks++;
      if (deb_a == 4'b1111) begin lat = k; break; end
    end
    chk("rst2_requal_lat", lat, 14);
    chk("rst2_ticks",      n_ticks, 3);

    // ---- TICK_DIV=1, STABLE_SAMPLES=2 instance ----
    raw_b = 4'b0100; lat = -1; rise_val = 0; low_tick = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (!tick_b) low_tick++;
      if (lat < 0 && deb_b[2]) begin lat = k; rise_val = int'(rise_b); end
    end
    chk("b_lat",  lat, 5);
    chk("b_rise", rise_val, 'b0100);
    chk("b_deb",  int'(deb_b), 'b0100);
    raw_b = 4'b0101;
    step();
    raw_b = 4'b0100;
    hi_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (!tick_b) low_tick++;
      if (deb_b[0] || chg_b) hi_cnt++;
    end
    chk("b_glitch",     hi_cnt, 0);
    chk("b_tick_always", low_tick, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
